// File: rtl/hex_entry_pkg.sv
// Shared key codes and FSM state type for the hex word entry block.
// No logic lives here.
// Imported by the entry FSM and by anything that drives its key port.
package hex_entry_pkg;

   // Key codes above the hex digits; codes 19-31 are reserved and ignored.
   localparam logic [4:0] KEY_BACKSPACE = 5'd16;
   localparam logic [4:0] KEY_ENTER     = 5'd17;
   localparam logic [4:0] KEY_CLEAR     = 5'd18;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_e;

endpackage

// File: rtl/hex_word_entry.sv
// Builds a word from hex key strokes and writes it to word memory at an auto-incrementing pointer.
// Latency: every key takes effect on the next clock; ENTER raises wr_req on the next clock.
// Backpressure: wr_req is held until wr_ack; keys and load_addr arriving during WRITE are dropped.
module hex_word_entry
   import hex_entry_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                key_valid,
   input  logic [4:0]                          key_code,
   input  logic                                load_addr,
   input  logic [ADDR_WIDTH-1:0]               start_addr,
   output logic                                wr_req,
   output logic [ADDR_WIDTH-1:0]               wr_addr,
   output logic [DATA_WIDTH-1:0]               wr_data,
   input  logic                                wr_ack,
   output logic [DATA_WIDTH-1:0]               entry_word,
   output logic [$clog2(DATA_WIDTH/4+1)-1:0]   digit_count,
   output logic                                busy
);

   localparam int HEX_DIGITS = DATA_WIDTH / 4;
   localparam int CNT_W      = $clog2(HEX_DIGITS + 1);

   state_e                state_q,   state_d;
   logic [DATA_WIDTH-1:0] entry_q,   entry_d;
   logic [CNT_W-1:0]      count_q,   count_d;
   logic [ADDR_WIDTH-1:0] ptr_q,     ptr_d;
   logic                  wr_req_q,  wr_req_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  busy_q,    busy_d;

   // Codes 0-15 have bit 4 clear; everything else is a command or reserved.
   logic                  key_is_hex;
   logic [DATA_WIDTH-1:0] key_nibble;

   assign key_is_hex = ~key_code[4];
   assign key_nibble = {{(DATA_WIDTH-4){1'b0}}, key_code[3:0]};

   // Next-state logic: digit entry and editing in IDLE, wait for acknowledge in WRITE.
   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      count_d   = count_q;
      ptr_d     = ptr_q;
      wr_req_d  = wr_req_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;

      case (state_q)
         ST_IDLE: begin
            // A pointer load wins over a key in the same cycle; the key is lost.
            if (load_addr) begin
               ptr_d = start_addr;
            end else if (key_valid) begin
               if (key_is_hex) begin
                  if (count_q < CNT_W'(HEX_DIGITS)) begin
                     entry_d = (entry_q << 4) | key_nibble;
                     count_d = count_q + CNT_W'(1);
                  end
               end else begin
                  case (key_code)
                     KEY_BACKSPACE: begin
                        if (count_q != '0) begin
                           entry_d = entry_q >> 4;
                           count_d = count_q - CNT_W'(1);
                        end
                     end
                     KEY_ENTER: begin
                        // An empty word is never written.
                        if (count_q != '0) begin
                           wr_data_d = entry_q;
                           wr_req_d  = 1'b1;
                           busy_d    = 1'b1;
                           state_d   = ST_WRITE;
                        end
                     end
                     KEY_CLEAR: begin
                        entry_d = '0;
                        count_d = '0;
                     end
                     default: begin
                        // reserved codes: no effect
                     end
                  endcase
               end
            end
         end

         ST_WRITE: begin
            // Request, address and data stay frozen until the memory acknowledges.
            if (wr_ack) begin
               wr_req_d = 1'b0;
               busy_d   = 1'b0;
               ptr_d    = ptr_q + ADDR_WIDTH'(1);
               entry_d  = '0;
               count_d  = '0;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset clears everything at once, abandoning any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         entry_q   <= '0;
         count_q   <= '0;
         ptr_q     <= '0;
         wr_req_q  <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         entry_q   <= entry_d;
         count_q   <= count_d;
         ptr_q     <= ptr_d;
         wr_req_q  <= wr_req_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_req      = wr_req_q;
   assign wr_addr     = ptr_q;
   assign wr_data     = wr_data_q;
   assign entry_word  = entry_q;
   assign digit_count = count_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_hex_word_entry.sv
// Scoreboard bench for hex_word_entry: a digit-list model predicts outputs per cycle and writes per ENTER.
// Stimulus is applied 1 time unit after each rising edge; the monitor samples on falling edges.
// Write requests are acknowledged by the stimulus process after a variable delay.
module tb_hex_word_entry;
   import hex_entry_pkg::*;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int ND = DW / 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key_valid = 1'b0;
   logic [4:0]    key_code = '0;
   logic          load_addr = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack = 1'b0;
   logic [DW-1:0] entry_word;
   logic [2:0]    digit_count;
   logic          busy;

   hex_word_entry #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .load_addr   (load_addr),
      .start_addr  (start_addr),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .entry_word  (entry_word),
      .digit_count (digit_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int unsigned at;
      logic [DW-1:0] entry;
      int            count;
      logic [AW-1:0] ptr;
      logic          req;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];

   // Reference model: the typed digits in entry order, a pointer, a pending-write flag.
   int m_dig[$];
   int m_ptr   = 0;
   bit m_write = 1'b0;

   function automatic logic [DW-1:0] m_word();
      int w = 0;
      foreach (m_dig[i]) w = w * 16 + m_dig[i];
      return DW'(w);
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_dig.delete();
      m_ptr   = 0;
      m_write = 1'b0;
   endfunction

   // One clock of stimulus: drive inputs, advance the model, queue the expected result.
   task automatic step(bit kv, logic [4:0] kc, bit la, logic [AW-1:0] sa, bit ack);
      exp_t e;
      @(posedge clk);
      #1;
      key_valid  = kv;
      key_code   = kc;
      load_addr  = la;
      start_addr = sa;
      wr_ack     = ack;
      if (m_write) begin
         if (ack) begin
            m_write = 1'b0;
            m_ptr   = (m_ptr + 1) % (1 << AW);
            m_dig.delete();
         end
      end else if (la) begin
         m_ptr = int'(sa);
      end else if (kv) begin
         if (kc < 16) begin
            if (m_dig.size() < ND) m_dig.push_back(int'(kc));
         end else if (kc == KEY_BACKSPACE) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
         end else if (kc == KEY_ENTER) begin
            if (m_dig.size() > 0) begin
               wr_t w;
               w.addr  = AW'(m_ptr);
               w.data  = m_word();
               wr_q.push_back(w);
               m_write = 1'b1;
            end
         end else if (kc == KEY_CLEAR) begin
            m_dig.delete();
         end
      end
      e.at    = cyc + 1;
      e.entry = m_word();
      e.count = m_dig.size();
      e.ptr   = AW'(m_ptr);
      e.req   = m_write;
      exp_q.push_back(e);
   endtask

   task automatic key(logic [4:0] k);
      step(1'b1, k, 1'b0, '0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic ack();
      step(1'b0, '0, 1'b0, '0, 1'b1);
   endtask

   task automatic check_reset_values(string tag);
      chk({tag, "_wr_req"},  32'(wr_req), 32'd0);
      chk({tag, "_busy"},    32'(busy), 32'd0);
      chk({tag, "_entry"},   32'(entry_word), 32'd0);
      chk({tag, "_count"},   32'(digit_count), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
   endtask

   // Asserts reset between edges while a write is pending; outputs must clear without a clock.
   task automatic reset_mid_write();
      @(posedge clk);
      #2;
      chk("pre_reset_wr_req", 32'(wr_req), 32'(m_write));
      reset = 1'b1;
      exp_q.delete();
      wr_q.delete();
      model_reset();
      #1;
      check_reset_values("async_reset");
      key_valid = 1'b0;
      load_addr = 1'b0;
      wr_ack    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: per-cycle output comparison plus write-transaction scoreboard.
   logic          prev_req = 1'b0;
   logic [AW-1:0] held_addr = '0;
   logic [DW-1:0] held_data = '0;
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("entry_word",  32'(entry_word), 32'(e.entry));
            chk("digit_count", 32'(digit_count), 32'(e.count));
            chk("wr_addr",     32'(wr_addr), 32'(e.ptr));
            chk("wr_req",      32'(wr_req), 32'(e.req));
            chk("busy",        32'(busy), 32'(e.req));
         end
         if (wr_req === 1'b1 && prev_req !== 1'b1) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
               n_bad++;
               $display("FAIL write_unexpected: got write to 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
            end else begin
               wr_t w;
               n_cmp--;
               w = wr_q.pop_front();
               chk("write_addr", 32'(wr_addr), 32'(w.addr));
               chk("write_data", 32'(wr_data), 32'(w.data));
            end
            held_addr = wr_addr;
            held_data = wr_data;
         end else if (wr_req === 1'b1) begin
            chk("hold_addr", 32'(wr_addr), 32'(held_addr));
            chk("hold_data", 32'(wr_data), 32'(held_data));
         end
         prev_req = wr_req;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;

      // Fifth digit ignored once the word is full.
      for (int d = 1; d <= 5; d++) key(5'(d));
      key(KEY_CLEAR);
      // Backspace edits and does not underflow.
      key(5'hA); key(5'hB); key(KEY_BACKSPACE); key(5'hC);
      for (int i = 0; i < 4; i++) key(KEY_BACKSPACE);
      // Load pointer, write one digit, acknowledge in the third request cycle.
      step(1'b0, '0, 1'b1, 8'h10, 1'b0);
      key(5'h7); key(KEY_ENTER); idle(); idle(); ack(); idle();
      // Keys and pointer loads during WRITE are dropped.
      key(5'h3); key(KEY_ENTER);
      key(5'h9); step(1'b0, '0, 1'b1, 8'h55, 1'b0);
      ack(); idle();
      // Pointer wrap, then ENTER on an empty word does nothing.
      step(1'b0, '0, 1'b1, 8'hFF, 1'b0);
      key(5'hB); key(5'hE); key(5'hE); key(5'hF); key(KEY_ENTER); ack();
      key(KEY_ENTER); idle();
      // Stray ack in IDLE, key dropped by simultaneous load, reserved code.
      key(5'h2); ack();
      step(1'b1, 5'h4, 1'b1, 8'h20, 1'b0);
      key(5'd25); key(5'd31);
      // Minimum spacing: ENTER, ack, ENTER.
      key(KEY_ENTER); ack(); key(5'h6); key(KEY_ENTER); ack();
      // Reset during a pending write.
      key(5'h5); key(KEY_ENTER); idle();
      reset_mid_write();
      idle();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         int unsigned r = $urandom_range(0, 99);
         logic [4:0] kc;
         if (r < 55)      kc = 5'($urandom_range(0, 15));
         else if (r < 67) kc = KEY_BACKSPACE;
         else if (r < 79) kc = KEY_ENTER;
         else if (r < 84) kc = KEY_CLEAR;
         else             kc = 5'($urandom_range(0, 31));
         if (m_write && $urandom_range(0, 199) == 0) begin
            reset_mid_write();
         end else if (m_write) begin
            step($urandom_range(0, 1) == 1, kc, $urandom_range(0, 7) == 0,
                 AW'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
         end else begin
            step($urandom_range(0, 3) != 0, kc, $urandom_range(0, 15) == 0,
                 AW'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
         end
      end

      key(5'h1); key(KEY_ENTER); ack();
      idle(); idle(); idle();
      @(negedge clk);
      @(negedge clk);
      chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("write_queue_drained",  32'(wr_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
